// File: rtl/onboard_io_pkg.sv
// Shared types for the board input peripheral: register selector and STATUS layout.
package onboard_io_pkg;

    typedef enum logic [1:0] {REG_SW, REG_BTN, REG_EVT, REG_STATUS} io_reg_e;

    localparam int EVT_CNT_W = 8;

    typedef struct packed {
        logic [15:0]          rsvd_hi;
        logic [EVT_CNT_W-1:0] evt_cnt;
        logic [6:0]           rsvd_lo;
        logic                 evt_any;
    } status_t;

endpackage

// File: rtl/debounce_cell.sv
// Purpose: 2-flop synchroniser plus tick-sampled debouncer for one raw pin.
// Latency: 2 clk sync, then DB_SAMPLES consecutive differing ticks to accept a level.
// Backpressure: none; free-running, rise is a one-cycle pulse on the accepting edge.
module debounce_cell #(
    parameter int DB_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_SAMPLES);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = (sync2 != stable);
    assign accept = tick && differ && (cnt == CW'(DB_SAMPLES - 1));
    assign rise   = accept && sync2;
    assign level  = stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                // Any sample matching the current level restarts acceptance.
                if (!differ) begin
                    cnt <= '0;
                end else if (accept) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/onboard_input.sv
// Purpose: CPU-readable switch/button block with sticky press events and a saturating press count.
// Latency: rdata/rvalid one cycle after rd_en & hit; inputs debounced over DB_SAMPLES ticks.
// Backpressure: none; every qualified read is answered the next cycle.
module onboard_input
    import onboard_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int          NSW        = 8,
    parameter int          NBTN       = 5,
    parameter int          SAMPLE_DIV = 250000,
    parameter int          DB_SAMPLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSW-1:0]  sw,
    input  logic [NBTN-1:0] btn,
    input  logic [31:0]     addr,
    input  logic            rd_en,
    output logic            hit,
    output logic [31:0]     rdata,
    output logic            rvalid,
    output logic            evt_any
);

    localparam int TW = $clog2(SAMPLE_DIV);

    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [NSW-1:0]       sw_level;
    logic [NSW-1:0]       sw_rise_unused;
    logic [NBTN-1:0]      btn_level;
    logic [NBTN-1:0]      btn_rise;
    logic [NBTN-1:0]      btn_evt;
    logic [NBTN-1:0]      evt_next;
    logic [NBTN-1:0]      evt_clr;
    logic [EVT_CNT_W-1:0] evt_cnt;
    logic [EVT_CNT_W-1:0] cnt_base;
    logic [EVT_CNT_W-1:0] cnt_next;
    logic [EVT_CNT_W:0]   cnt_sum;
    logic [4:0]           rise_pop;
    logic                 rd_fire;
    logic                 addr_lo_unused;
    io_reg_e              sel;
    status_t              status;
    logic [31:0]          rd_val;

    assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        debounce_cell #(.DB_SAMPLES(DB_SAMPLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (sw[i]),
            .tick  (tick),
            .level (sw_level[i]),
            .rise  (sw_rise_unused[i])
        );
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        debounce_cell #(.DB_SAMPLES(DB_SAMPLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (btn[i]),
            .tick  (tick),
            .level (btn_level[i]),
            .rise  (btn_rise[i])
        );
    end

    // Byte offset within a word does not select anything.
    assign addr_lo_unused = ^addr[1:0];
    assign hit            = (addr[31:4] == BASE_ADDR[31:4]);
    assign rd_fire        = rd_en && hit;
    assign sel            = io_reg_e'(addr[3:2]);

    always_comb begin
        status         = '0;
        status.evt_cnt = evt_cnt;
        status.evt_any = evt_any;
        rd_val         = '0;
        case (sel)
            REG_SW:     rd_val = {{(32 - NSW){1'b0}}, sw_level};
            REG_BTN:    rd_val = {{(32 - NBTN){1'b0}}, btn_level};
            REG_EVT:    rd_val = {{(32 - NBTN){1'b0}}, btn_evt};
            REG_STATUS: rd_val = status;
            default:    rd_val = '0;
        endcase
    end

    // Clear only what the read returns; a press on the same edge is ORed back in.
    always_comb begin
        evt_clr  = (rd_fire && sel == REG_EVT) ? btn_evt : '0;
        evt_next = (btn_evt & ~evt_clr) | btn_rise;
        rise_pop = '0;
        for (int i = 0; i < NBTN; i++) begin
            rise_pop = rise_pop + 5'(btn_rise[i]);
        end
        cnt_base = (rd_fire && sel == REG_STATUS) ? '0 : evt_cnt;
        cnt_sum  = {1'b0, cnt_base} + (EVT_CNT_W + 1)'(rise_pop);
        cnt_next = cnt_sum[EVT_CNT_W] ? '1 : cnt_sum[EVT_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_evt <= '0;
            evt_cnt <= '0;
            evt_any <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            btn_evt <= evt_next;
            evt_cnt <= cnt_next;
            evt_any <= |evt_next;
            rvalid  <= rd_fire;
            if (rd_fire) begin
                rdata <= rd_val;
            end
        end
    end

endmodule
